// File: rtl/clk_sched_pkg.sv
// Shared types and helpers for the clock scheduler: FSM state encoding,
// default divisor width and the prescale ratio calculation.
package clk_sched_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        APPLY = 1'b1
    } state_t;

    localparam int DIV_W_DEF = 16;

    function automatic int calc_pre(input int clk_hz, input int base_hz);
        return clk_hz / base_hz;
    endfunction

endpackage

// File: rtl/clk_sched_ctrl_ch_divider.sv
// One output channel: counts shared base ticks up to its divisor, pulses
// tick on wrap and toggles its square-wave output on the same edge.
module ch_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             base_tick,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic             load_en,
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             en;
    logic             active;
    logic             wrap;

    assign active = en && (div != '0);
    assign wrap   = active && base_tick && (cnt == div - DIV_W'(1));
    // A reconfiguration in the same cycle suppresses the pulse.
    assign tick   = wrap && !load;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            div     <= '0;
            en      <= 1'b0;
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (load) begin
            div     <= load_div;
            en      <= load_en;
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (!active) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (base_tick) begin
            if (wrap) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_sched_ctrl.sv
// Multi-channel clock scheduler: a free-running prescaler feeds N_CH
// programmable dividers, reconfigured one channel at a time through a RUN/APPLY FSM.
module clk_sched_ctrl
    import clk_sched_pkg::*;
#(
    parameter  int CLK_HZ  = 100_000_000,
    parameter  int BASE_HZ = 10_000,
    parameter  int N_CH    = 4,
    parameter  int DIV_W   = DIV_W_DEF,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_out,
    output logic             busy
);

    localparam int PRE   = calc_pre(CLK_HZ, BASE_HZ);
    localparam int PRE_W = $clog2(PRE);

    logic [PRE_W-1:0] pre_cnt;
    logic             base_tick;
    state_t           state;
    logic [CH_W-1:0]  cap_ch;
    logic [DIV_W-1:0] cap_div;
    logic             cap_en;
    logic [N_CH-1:0]  load;

    assign base_tick = (pre_cnt == PRE_W'(PRE - 1));

    always_ff @(posedge clk_in) begin
        if (rst || base_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign cfg_ready = (state == RUN) && !rst;
    assign busy      = (state == APPLY);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state   <= RUN;
            cap_ch  <= '0;
            cap_div <= '0;
            cap_en  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cfg_valid) begin
                        state   <= APPLY;
                        cap_ch  <= cfg_ch;
                        cap_div <= cfg_div;
                        cap_en  <= cfg_en;
                    end
                end
                APPLY:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Out-of-range channel indices match no divider, so the write is a no-op.
    always_comb begin
        load = '0;
        for (int i = 0; i < N_CH; i++) begin
            load[i] = (state == APPLY) && (cap_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ch_divider #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .base_tick(base_tick),
            .load     (load[g]),
            .load_div (cap_div),
            .load_en  (cap_en),
            .tick     (tick[g]),
            .clk_out  (clk_out[g])
        );
    end

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Directed bench for clk_sched_ctrl with CLK_HZ=100, BASE_HZ=10 (PRE=10), four channels.
module tb_clk_sched_ctrl;

    logic        clk_in;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic [3:0]  tick;
    logic [3:0]  clk_out;
    logic        busy;

    int vec;
    int errs;
    int pc;
    int tk_cnt [4];
    int gmin, gmax, rgap, misalign;
    logic act;

    clk_sched_ctrl #(
        .CLK_HZ (100),
        .BASE_HZ(10),
        .N_CH   (4),
        .DIV_W  (16)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .tick     (tick),
        .clk_out  (clk_out),
        .busy     (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; pc mirrors the expected prescaler value of the current cycle.
    task automatic step();
        @(posedge clk_in);
        if (rst) pc = 0;
        else     pc = (pc + 1) % 10;
        #1;
    endtask

    task automatic measure(input int ch, input int ncyc, input logic [3:0] idle);
        int   last_tk;
        int   last_rise;
        logic prev_clk;
        for (int k = 0; k < 4; k++) tk_cnt[k] = 0;
        gmin = 1000; gmax = 0; rgap = 0; misalign = 0; act = 1'b0;
        last_tk = -1; last_rise = -1; prev_clk = clk_out[ch];
        for (int c = 1; c <= ncyc; c++) begin
            step();
            for (int k = 0; k < 4; k++) if (tick[k]) tk_cnt[k]++;
            if (tick[ch]) begin
                if (pc != 9) misalign++;
                if (last_tk >= 0) begin
                    if (c - last_tk < gmin) gmin = c - last_tk;
                    if (c - last_tk > gmax) gmax = c - last_tk;
                end
                last_tk = c;
            end
            if (clk_out[ch] && !prev_clk) begin
                if (last_rise >= 0) rgap = c - last_rise;
                last_rise = c;
            end
            prev_clk = clk_out[ch];
            if (((tick | clk_out) & idle) != 4'b0) act = 1'b1;
        end
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [15:0] dv, input logic en);
        vec++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL wr_ready: got %0b want 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_en = en;
        step();
        cfg_valid = 1'b0;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy: got %0b want 1", busy); end
        step();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0; cfg_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vec++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %0b want 0", cfg_ready); end
            vec++; if (tick !== 4'b0) begin errs++; $display("FAIL rst_tick: got %b want 0000", tick); end
            vec++; if (clk_out !== 4'b0) begin errs++; $display("FAIL rst_clk: got %b want 0000", clk_out); end
            vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0b want 0", busy); end
        end
        rst = 1'b0;
        #1;
        vec++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL rst_rel_ready: got %0b want 1", cfg_ready); end
    endtask

    task automatic test_div2();
        write_cfg(2'd0, 16'd2, 1'b1);
        measure(0, 120, 4'b1110);
        vec++; if (tk_cnt[0] != 6) begin errs++; $display("FAIL div2_count: got %0d want 6", tk_cnt[0]); end
        vec++; if (gmin != 20 || gmax != 20) begin errs++; $display("FAIL div2_gap: got %0d..%0d want 20", gmin, gmax); end
        vec++; if (rgap != 40) begin errs++; $display("FAIL div2_period: got %0d want 40", rgap); end
        vec++; if (misalign != 0) begin errs++; $display("FAIL div2_align: got %0d want 0", misalign); end
        vec++; if (act !== 1'b0) begin errs++; $display("FAIL div2_others: got %0b want 0", act); end
    endtask

    task automatic test_div1_div0();
        write_cfg(2'd1, 16'd1, 1'b1);
        measure(1, 60, 4'b1100);
        vec++; if (tk_cnt[1] != 6) begin errs++; $display("FAIL div1_count: got %0d want 6", tk_cnt[1]); end
        vec++; if (gmin != 10 || gmax != 10) begin errs++; $display("FAIL div1_gap: got %0d..%0d want 10", gmin, gmax); end
        vec++; if (rgap != 20) begin errs++; $display("FAIL div1_period: got %0d want 20", rgap); end
        vec++; if (misalign != 0) begin errs++; $display("FAIL div1_align: got %0d want 0", misalign); end
        vec++; if (tk_cnt[0] != 3) begin errs++; $display("FAIL div1_ch0_undisturbed: got %0d want 3", tk_cnt[0]); end
        write_cfg(2'd1, 16'd0, 1'b1);
        measure(1, 40, 4'b1110);
        vec++; if (tk_cnt[1] != 0) begin errs++; $display("FAIL div0_count: got %0d want 0", tk_cnt[1]); end
        vec++; if (act !== 1'b0) begin errs++; $display("FAIL div0_idle: got %0b want 0", act); end
    endtask

    task automatic test_reconfig_collision();
        int   n;
        logic low_ok;
        n = 0;
        while (!(tick[0] && !clk_out[0]) && n < 100) begin
            step();
            n++;
        end
        vec++; if (n >= 100) begin errs++; $display("FAIL coll_sync: got timeout want tick[0] with clk_out[0]=0"); end
        for (int i = 0; i < 19; i++) step();
        vec++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL coll_ready: got %0b want 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3; cfg_en = 1'b1;
        step();
        cfg_valid = 1'b0;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL coll_busy: got %0b want 1", busy); end
        vec++; if (tick[0] !== 1'b0) begin errs++; $display("FAIL coll_no_tick: got %0b want 0", tick[0]); end
        vec++; if (clk_out[0] !== 1'b1) begin errs++; $display("FAIL coll_clk_before: got %0b want 1", clk_out[0]); end
        step();
        vec++; if (clk_out[0] !== 1'b0) begin errs++; $display("FAIL coll_clk_forced: got %0b want 0", clk_out[0]); end
        n = 1;
        low_ok = 1'b1;
        while (!tick[0] && n < 60) begin
            if (clk_out[0]) low_ok = 1'b0;
            step();
            n++;
        end
        vec++; if (n != 30) begin errs++; $display("FAIL coll_next_tick: got %0d cycles want 30", n); end
        vec++; if (low_ok !== 1'b1) begin errs++; $display("FAIL coll_clk_low: got toggle want steady 0"); end
    endtask

    task automatic test_back_to_back();
        vec++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready0: got %0b want 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd1; cfg_en = 1'b1;
        step();
        vec++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready1: got %0b want 0", cfg_ready); end
        cfg_ch = 2'd3; cfg_div = 16'd1; cfg_en = 1'b1;
        step();
        vec++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready2: got %0b want 1", cfg_ready); end
        cfg_ch = 2'd1; cfg_div = 16'd1; cfg_en = 1'b1;
        step();
        vec++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready3: got %0b want 0", cfg_ready); end
        cfg_ch = 2'd0; cfg_div = 16'd1; cfg_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_end: got %0b want 0", busy); end
        measure(0, 60, 4'b1000);
        vec++; if (tk_cnt[0] != 2) begin errs++; $display("FAIL b2b_ch0: got %0d want 2", tk_cnt[0]); end
        vec++; if (tk_cnt[1] != 6) begin errs++; $display("FAIL b2b_ch1: got %0d want 6", tk_cnt[1]); end
        vec++; if (tk_cnt[2] != 6) begin errs++; $display("FAIL b2b_ch2: got %0d want 6", tk_cnt[2]); end
        vec++; if (tk_cnt[3] != 0) begin errs++; $display("FAIL b2b_ch3: got %0d want 0", tk_cnt[3]); end
        vec++; if (act !== 1'b0) begin errs++; $display("FAIL b2b_ch3_idle: got %0b want 0", act); end
    endtask

    task automatic test_reset_mid_apply();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd1; cfg_en = 1'b1;
        step();
        cfg_valid = 1'b0;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL rma_busy: got %0b want 1", busy); end
        rst = 1'b1;
        step();
        vec++; if (tick !== 4'b0) begin errs++; $display("FAIL rma_tick: got %b want 0000", tick); end
        vec++; if (clk_out !== 4'b0) begin errs++; $display("FAIL rma_clk: got %b want 0000", clk_out); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rma_busy_clr: got %0b want 0", busy); end
        vec++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL rma_ready: got %0b want 0", cfg_ready); end
        rst = 1'b0;
        #1;
        vec++; if (cfg_ready !== 1'b1) begin errs++; $display("FAIL rma_ready_rel: got %0b want 1", cfg_ready); end
        measure(3, 40, 4'b1111);
        vec++; if (tk_cnt[3] != 0) begin errs++; $display("FAIL rma_discard: got %0d want 0", tk_cnt[3]); end
        vec++; if (act !== 1'b0) begin errs++; $display("FAIL rma_all_idle: got %0b want 0", act); end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        pc   = 0;
        test_reset();
        test_div2();
        test_div1_div0();
        test_reconfig_collision();
        test_back_to_back();
        test_reset_mid_apply();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
